// File: rtl/dff_test_pkg.sv
// Shared definitions for the D flip-flop self-test engine: FSM encodings,
// LFSR polynomial, default seed and the DUT reset-hold length.
package dff_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RST_DUT = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'h01;
    localparam int         RST_HOLD     = 2;

    // Fibonacci step: shift left, XOR of the tapped bits enters at bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dff_self_test_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous seed load and step enable.
module lfsr8
    import dff_test_pkg::*;
#(
    parameter logic [7:0] INIT = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       en,
    output logic [7:0] state
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
        end else if (load) begin
            state <= seed;
        end else if (en) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/dff_self_test.sv
// Built-in self-test for a D flip-flop cell: resets it, streams LFSR bits into D,
// checks Q one cycle later and reports a saturating error count and verdict.
module dff_self_test
    import dff_test_pkg::*;
#(
    parameter int         NUM_VECTORS = 64,
    parameter logic [7:0] SEED        = 8'h01,
    parameter int         ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             q_in,
    output logic             d_out,
    output logic             dut_reset,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? DEFAULT_SEED : SEED;
    localparam int               CNT_W    = $clog2(NUM_VECTORS + 2);
    localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] LAST_RST = CNT_W'(RST_HOLD - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_exp;

    logic             w_load;
    logic             w_lfsr_en;
    logic             w_lfsr_bit;
    logic [6:0]       w_lfsr_unused;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_load    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    assign w_lfsr_en = ((r_state == ST_RST_DUT) && (r_cnt == LAST_RST)) ||
                       ((r_state == ST_RUN) && (r_cnt != LAST_VEC));

    lfsr8 #(
        .INIT (SEED_EFF)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .seed  (SEED_EFF),
        .en    (w_lfsr_en),
        .state ({w_lfsr_unused, w_lfsr_bit})
    );

    // The first RUN cycle has no previous expected bit, so its compare is skipped.
    always_comb begin
        w_mismatch = 1'b0;
        case (r_state)
            ST_RST_DUT: w_mismatch = (r_cnt == LAST_RST) && q_in;
            ST_RUN:     w_mismatch = (r_cnt != '0) && (q_in != r_exp);
            ST_DRAIN:   w_mismatch = (q_in != r_exp);
            default:    w_mismatch = 1'b0;
        endcase
        w_err_next = w_mismatch ? sat_inc(err_count) : err_count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_exp     <= 1'b0;
            d_out     <= 1'b0;
            dut_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state   <= ST_RST_DUT;
                        r_cnt     <= '0;
                        dut_reset <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                    end
                end
                ST_RST_DUT: begin
                    err_count <= w_err_next;
                    if (r_cnt == LAST_RST) begin
                        r_state   <= ST_RUN;
                        r_cnt     <= '0;
                        dut_reset <= 1'b0;
                        d_out     <= w_lfsr_bit;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    err_count <= w_err_next;
                    r_exp     <= d_out;
                    if (r_cnt == LAST_VEC) begin
                        r_state <= ST_DRAIN;
                        d_out   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        d_out <= w_lfsr_bit;
                    end
                end
                ST_DRAIN: begin
                    err_count <= w_err_next;
                    r_state   <= ST_DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    pass      <= (w_err_next == '0);
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_self_test.sv
// Directed bench: three self-test engines (good hookup, inverted hookup with a
// 3-bit counter, zero seed) run in lockstep against behavioural flip-flops.
module tb_dff_self_test;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic start    = 1'b0;
    logic inv_main = 1'b0;

    always #5 clk = ~clk;

    logic       m_d, m_dr, m_busy, m_done, m_pass, m_q, m_qin;
    logic [7:0] m_err;
    logic       s_d, s_dr, s_busy, s_done, s_pass, s_q, s_qin;
    logic [2:0] s_err;
    logic       z_d, z_dr, z_busy, z_done, z_pass, z_q, z_qin;
    logic [7:0] z_err;

    // Flip-flops under test: async active-high reset, Q updates on the clock edge.
    always_ff @(posedge clk or posedge m_dr) if (m_dr) m_q <= 1'b0; else m_q <= m_d;
    always_ff @(posedge clk or posedge s_dr) if (s_dr) s_q <= 1'b0; else s_q <= s_d;
    always_ff @(posedge clk or posedge z_dr) if (z_dr) z_q <= 1'b0; else z_q <= z_d;

    assign m_qin = inv_main ? ~m_q : m_q;
    assign s_qin = ~s_q;
    assign z_qin = z_q;

    dff_self_test #(.NUM_VECTORS(16), .SEED(8'h01), .ERR_W(8)) u_main (
        .clk(clk), .reset(reset), .start(start), .q_in(m_qin), .d_out(m_d),
        .dut_reset(m_dr), .busy(m_busy), .done(m_done), .pass(m_pass), .err_count(m_err));

    dff_self_test #(.NUM_VECTORS(16), .SEED(8'h01), .ERR_W(3)) u_sat (
        .clk(clk), .reset(reset), .start(start), .q_in(s_qin), .d_out(s_d),
        .dut_reset(s_dr), .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err));

    dff_self_test #(.NUM_VECTORS(16), .SEED(8'h00), .ERR_W(8)) u_seed0 (
        .clk(clk), .reset(reset), .start(start), .q_in(z_qin), .d_out(z_d),
        .dut_reset(z_dr), .busy(z_busy), .done(z_done), .pass(z_pass), .err_count(z_err));

    // Seed 8'h01 stream, first bit in bit 0: 1,0,0,0,1,1,1,0,0,0,1,0,0,1,0,1.
    localparam logic [15:0] EXP_STREAM = 16'b1010_0100_0111_0001;

    int          total = 0;
    int          bad   = 0;
    int          busy_m, busy_z, done_at;
    logic [15:0] stream_m, stream_z;
    logic [1:0]  dout_idle_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Called at the negedge right after the start-sampling edge (cycle 0).
    task automatic observe(input int ncyc);
        busy_m = 0; busy_z = 0; done_at = -1;
        stream_m = '0; stream_z = '0; dout_idle_m = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);
            if (m_busy) busy_m++;
            if (z_busy) busy_z++;
            if (c >= 2 && c < 18) begin
                stream_m[c-2] = m_d;
                stream_z[c-2] = z_d;
            end
            if (c == 1)  dout_idle_m[0] = m_d;
            if (c == 18) dout_idle_m[1] = m_d;
            if (m_done && done_at < 0) done_at = c;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_d_out",     m_d,    1'b0);
        check("rst_dut_reset", m_dr,   1'b0);
        check("rst_busy",      m_busy, 1'b0);
        check("rst_done",      m_done, 1'b0);
        check("rst_pass",      m_pass, 1'b0);
        check("rst_err",       m_err,  8'd0);
        check("rst_sat_err",   s_err,  3'd0);
        reset = 1'b0;

        // Good hookup, inverted-sat hookup and zero seed all run together.
        pulse_start();
        observe(20);
        check("run1_busy_len",   busy_m,      32'd19);
        check("run1_done_at",    done_at,     32'd19);
        check("run1_stream",     stream_m,    EXP_STREAM);
        check("run1_first5",     stream_m[4:0], 5'b10001);
        check("run1_dout_idle",  dout_idle_m, 2'b00);
        check("run1_pass",       m_pass,      1'b1);
        check("run1_err",        m_err,       8'd0);
        check("run1_done",       m_done,      1'b1);
        check("sat_err",         s_err,       3'd7);
        check("sat_pass",        s_pass,      1'b0);
        check("seed0_stream",    stream_z,    EXP_STREAM);
        check("seed0_busy_len",  busy_z,      32'd19);
        check("seed0_pass",      z_pass,      1'b1);

        // Inverted hookup on the main engine: 1 reset + 16 data errors.
        inv_main = 1'b1;
        pulse_start();
        observe(20);
        check("inv_err",     m_err,   8'd17);
        check("inv_pass",    m_pass,  1'b0);
        check("inv_done_at", done_at, 32'd19);
        check("sat_err2",    s_err,   3'd7);

        // Abort during the 5th RUN cycle with an asynchronous reset.
        inv_main = 1'b0;
        pulse_start();
        repeat (6) @(negedge clk);
        check("abort_in_run",    m_dr,  1'b0);
        check("abort_sat_partial", s_err, 3'd4);
        reset = 1'b1;
        #1;
        check("abort_busy",      m_busy, 1'b0);
        check("abort_dut_reset", m_dr,   1'b0);
        check("abort_d_out",     m_d,    1'b0);
        check("abort_done",      m_done, 1'b0);
        check("abort_pass",      m_pass, 1'b0);
        check("abort_sat_err",   s_err,  3'd0);
        @(negedge clk) reset = 1'b0;
        pulse_start();
        observe(20);
        check("fresh_busy_len", busy_m,   32'd19);
        check("fresh_stream",   stream_m, EXP_STREAM);
        check("fresh_pass",     m_pass,   1'b1);
        check("fresh_err",      m_err,    8'd0);

        // Start held high: no restart while busy, relaunch right after DONE.
        inv_main = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        observe(20);
        check("hold_busy_len", busy_m,  32'd19);
        check("hold_done_at",  done_at, 32'd19);
        check("hold_err",      m_err,   8'd17);
        @(negedge clk);
        check("hold_restart_busy", m_busy, 1'b1);
        check("hold_restart_done", m_done, 1'b0);
        check("hold_restart_err",  m_err,  8'd0);
        check("hold_restart_rst",  m_dr,   1'b1);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
